// File: rtl/dma_bus_arbiter_if.sv
// Bus request/grant handshake between the CPU-side arbiter, the CPU and the DMA controller.
// The slave modport is the arbiter's view; the master modport is the view of whoever drives it.
interface dma_bus_arbiter_if;
  logic dma_start;
  logic cpu_mem_busy;
  logic BR;
  logic cmd;
  logic BG;
  logic cpu_stall;
  logic dma_busy;
  logic dma_done;
  logic dma_error;

  modport slave (
    input  dma_start, cpu_mem_busy, BR,
    output cmd, BG, cpu_stall, dma_busy, dma_done, dma_error
  );

  modport master (
    output dma_start, cpu_mem_busy, BR,
    input  cmd, BG, cpu_stall, dma_busy, dma_done, dma_error
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// CPU-side bus owner for the DMA BR/BG handshake: commands the DMA, grants the bus, reclaims it.
// Optional macro ARB_STARVE_GUARD_EN holds off re-granting for MIN_CPU_CYCLES after each release.
module dma_bus_arbiter #(
  parameter int unsigned GRANT_TIMEOUT  = 32,
  parameter int unsigned MIN_CPU_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               reset_n,
  dma_bus_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DRAIN,
    S_GRANT,
    S_RELEASE
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(GRANT_TIMEOUT - 1);

  if (GRANT_TIMEOUT < 13 || GRANT_TIMEOUT > 255 || MIN_CPU_CYCLES > 255) begin : g_param_check
    $error("dma_bus_arbiter: GRANT_TIMEOUT or MIN_CPU_CYCLES out of range");
  end

  state_t     r_state;
  logic [7:0] r_grant_cnt;
  logic       r_cmd;
  logic       r_bg;
  logic       r_stall;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic       w_guard_clear;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] GUARD_LOAD = 8'(MIN_CPU_CYCLES);

  logic [7:0] r_guard_cnt;

  // Reload on the release cycle; count down on every edge the CPU owns the bus.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_guard_cnt <= '0;
    end else if (r_state == S_RELEASE) begin
      r_guard_cnt <= GUARD_LOAD;
    end else if (r_state != S_GRANT && r_guard_cnt != 8'd0) begin
      r_guard_cnt <= r_guard_cnt - 8'd1;
    end
  end

  assign w_guard_clear = (r_guard_cnt == 8'd0);
`else
  assign w_guard_clear = 1'b1;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_grant_cnt <= '0;
      r_cmd       <= 1'b0;
      r_bg        <= 1'b0;
      r_stall     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.dma_start) begin
            r_state <= S_CMD;
            r_cmd   <= 1'b1;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
          end
        end

        S_CMD: begin
          if (bus.BR && w_guard_clear) begin
            r_stall <= 1'b1;
            if (bus.cpu_mem_busy) begin
              r_state <= S_DRAIN;
            end else begin
              r_state     <= S_GRANT;
              r_bg        <= 1'b1;
              r_grant_cnt <= '0;
            end
          end
        end

        S_DRAIN: begin
          if (!bus.cpu_mem_busy) begin
            r_state     <= S_GRANT;
            r_bg        <= 1'b1;
            r_grant_cnt <= '0;
          end
        end

        S_GRANT: begin
          // A BR drop on the timeout edge is still a clean completion.
          if (!bus.BR || r_grant_cnt == TIMEOUT_LAST) begin
            r_state <= S_RELEASE;
            r_bg    <= 1'b0;
            r_cmd   <= 1'b0;
            r_stall <= 1'b0;
            r_done  <= 1'b1;
            if (bus.BR) begin
              r_error <= 1'b1;
            end
          end else begin
            r_grant_cnt <= r_grant_cnt + 8'd1;
          end
        end

        S_RELEASE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_cmd   <= 1'b0;
          r_bg    <= 1'b0;
          r_stall <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.BG        = r_bg;
  assign bus.cpu_stall = r_stall;
  assign bus.dma_busy  = r_busy;
  assign bus.dma_done  = r_done;
  assign bus.dma_error = r_error;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a transfer-level model checked every cycle plus literal checkpoints.
`timescale 1ns/1ps
module tb_dma_bus_arbiter;
  localparam int T    = 32;
  localparam int MINC = 4;

  logic CLK     = 1'b0;
  logic reset_n = 1'b0;
  logic br_en   = 1'b0;

  dma_bus_arbiter_if bus();

  // The DMA controller answers cmd with BR until it decides it is finished.
  assign bus.BR = bus.cmd & br_en;

  dma_bus_arbiter #(.GRANT_TIMEOUT(T), .MIN_CPU_CYCLES(MINC)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks  = 0;
  int n_errors  = 0;
  int bg_cycles = 0;

  // Transfer-level model: is a transfer open, is the bus lent out, for how many cycles so far.
  bit m_active = 0;
  bit m_cmd    = 0;
  bit m_grant  = 0;
  bit m_stall  = 0;
  bit m_done   = 0;
  bit m_err    = 0;
  int m_held   = 0;
  int m_guard  = 0;

  always @(posedge CLK or negedge reset_n) begin
    bit sees_br;
    int guard_before;
    if (!reset_n) begin
      m_active = 0; m_cmd = 0; m_grant = 0; m_stall = 0;
      m_done = 0; m_err = 0; m_held = 0; m_guard = 0;
    end else begin
      sees_br      = m_cmd & br_en;
      guard_before = m_guard;
      if (!m_grant && m_guard > 0) m_guard--;
      if (m_done) begin
        m_done   = 0;
        m_active = 0;
`ifdef ARB_STARVE_GUARD_EN
        m_guard  = MINC;
`endif
      end else if (!m_active) begin
        if (bus.dma_start) begin
          m_active = 1;
          m_cmd    = 1;
          m_err    = 0;
        end
      end else if (m_grant) begin
        if (!sees_br || m_held == T) begin
          if (sees_br) m_err = 1;
          m_grant = 0;
          m_cmd   = 0;
          m_stall = 0;
          m_done  = 1;
        end else begin
          m_held++;
        end
      end else if (guard_before == 0 && (m_stall || sees_br)) begin
        m_stall = 1;
        if (!bus.cpu_mem_busy) begin
          m_grant = 1;
          m_held  = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    logic [5:0] got;
    logic [5:0] req;
    got = {bus.cmd, bus.BG, bus.cpu_stall, bus.dma_busy, bus.dma_done, bus.dma_error};
    req = {m_cmd, m_grant, m_stall, m_active, m_done, m_err};
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL model @%0t cmd/bg/stall/busy/done/err got %b required %b", $time, got, req);
    end
    if (bus.BG === 1'b1) bg_cycles++;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s @%0t got %b required %b", name, $time, got, req);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_errors++;
      $display("FAIL %s @%0t got %0d required %0d", name, $time, got, req);
    end
  endtask

  task automatic pulse_start();
    tick();
    bus.dma_start = 1'b1;
    tick();
    bus.dma_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (bus.dma_done === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: dma_done got 0 required 1 within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic settle();
    repeat (MINC + 2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dma_start    = 1'b0;
    bus.cpu_mem_busy = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_cmd", bus.cmd, 1'b0);
    chk("rst_bg", bus.BG, 1'b0);
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_done", bus.dma_done, 1'b0);
    chk("rst_err", bus.dma_error, 1'b0);
    chk("rst_busy", bus.dma_busy, 1'b0);

    // Normal 12-cycle grant, with an ignored dma_start mid-grant.
    br_en = 1'b1; bg_cycles = 0;
    pulse_start();
    chk("s2_cmd", bus.cmd, 1'b1);
    chk("s2_bg_early", bus.BG, 1'b0);
    tick();
    chk("s2_bg_k2", bus.BG, 1'b1);
    chk("s2_stall", bus.cpu_stall, 1'b1);
    tick(); bus.dma_start = 1'b1;
    tick(); bus.dma_start = 1'b0;
    repeat (9) tick();
    br_en = 1'b0;
    tick();
    chk("s2_done", bus.dma_done, 1'b1);
    chk("s2_err", bus.dma_error, 1'b0);
    chk("s2_bg_off", bus.BG, 1'b0);
    chk_int("s2_bg_cycles", bg_cycles, 12);
    tick();
    chk("s2_idle_busy", bus.dma_busy, 1'b0);
    chk("s2_done_once", bus.dma_done, 1'b0);

    // CPU access in flight for three decision edges.
    settle();
    br_en = 1'b1; bg_cycles = 0;
    tick(); bus.dma_start = 1'b1; bus.cpu_mem_busy = 1'b1;
    tick(); bus.dma_start = 1'b0;
    tick();
    chk("s3_drain_stall", bus.cpu_stall, 1'b1);
    chk("s3_drain_bg1", bus.BG, 1'b0);
    tick();
    chk("s3_drain_bg2", bus.BG, 1'b0);
    tick();
    chk("s3_drain_bg3", bus.BG, 1'b0);
    bus.cpu_mem_busy = 1'b0;
    tick();
    chk("s3_bg_after", bus.BG, 1'b1);
    tick(); br_en = 1'b0;
    wait_done(5, "s3_done");
    chk_int("s3_bg_cycles", bg_cycles, 2);

    // BR never drops: timeout after 32 granted cycles.
    settle();
    br_en = 1'b1; bg_cycles = 0;
    pulse_start();
    wait_done(60, "s4_done");
    chk("s4_err", bus.dma_error, 1'b1);
    chk("s4_cmd_off", bus.cmd, 1'b0);
    chk("s4_bg_off", bus.BG, 1'b0);
    chk_int("s4_bg_cycles", bg_cycles, 32);
    repeat (3) tick();
    chk("s4_err_held", bus.dma_error, 1'b1);
    br_en = 1'b0;
    settle();
    pulse_start();
    chk("s4_err_cleared", bus.dma_error, 1'b0);
    repeat (3) tick();
    chk("s4_cmd_held", bus.cmd, 1'b1);
    chk("s4_no_bg_without_br", bus.BG, 1'b0);
    br_en = 1'b1;
    tick();
    chk("s4_bg_on_br", bus.BG, 1'b1);
    tick(); br_en = 1'b0;
    wait_done(5, "s4b_done");
    chk("s4b_err", bus.dma_error, 1'b0);

    // BR drops on the timeout edge itself: normal completion.
    settle();
    br_en = 1'b1; bg_cycles = 0;
    pulse_start();
    tick();
    repeat (31) tick();
    br_en = 1'b0;
    wait_done(3, "s5_done");
    chk("s5_err", bus.dma_error, 1'b0);
    chk_int("s5_bg_cycles", bg_cycles, 32);

    // Asynchronous reset in the 5th granted cycle.
    settle();
    br_en = 1'b1;
    pulse_start();
    tick();
    repeat (4) tick();
    chk("s6_bg_before", bus.BG, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_bg_async", bus.BG, 1'b0);
    chk("s6_cmd_async", bus.cmd, 1'b0);
    chk("s6_done_async", bus.dma_done, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    bg_cycles = 0;
    pulse_start();
    tick();
    br_en = 1'b0;
    wait_done(5, "s6_done");
    chk("s6_err", bus.dma_error, 1'b0);
    chk_int("s6_bg_cycles", bg_cycles, 1);

    // dma_start in the cycle right after dma_done.
    br_en = 1'b1;
    pulse_start();
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s7_guard_bg", bus.BG, 1'b0);
      chk("s7_guard_stall", bus.cpu_stall, 1'b0);
    end
`endif
    tick();
    chk("s7_bg", bus.BG, 1'b1);
    tick(); br_en = 1'b0;
    wait_done(5, "s7_done");

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
CPU-side bus owner and responder for the DMA controller's bus request/grant handshake.
- Accepts a one-cycle DMA start request from the CPU and drives the DMA `cmd` line.
- Answers the DMA's BR with BG once the CPU's in-flight memory access has drained, and stalls the CPU while the DMA owns the bus.
- Reclaims the bus when BR falls, then reports completion (or timeout) to the CPU.

Parameters:
- GRANT_TIMEOUT, 32: max consecutive BG cycles before the bus is forcibly reclaimed; legal range 13..255.
- MIN_CPU_CYCLES, 4: guaranteed CPU-owned cycles between grants (used only with ARB_STARVE_GUARD_EN).

Ports:
- CLK  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- dma_start  in  1  one-cycle pulse from CPU: begin DMA transfer.
- cpu_mem_busy  in  1  CPU memory access in progress; the bus must not be granted while high.
- BR  in  1  bus request from the DMA controller (combinationally follows `cmd` until the DMA finishes).
- cmd  out  1  DMA command to the DMA controller.
- BG  out  1  bus grant to the DMA controller.
- cpu_stall  out  1  CPU must not start memory accesses while high.
- dma_busy  out  1  high whenever state is not IDLE.
- dma_done  out  1  one-cycle completion pulse to the CPU.
- dma_error  out  1  sticky timeout flag; cleared by the next accepted dma_start or by reset.

Behaviour:
- All outputs are registered. Reset (async, reset_n=0) forces immediately:
  - cmd=0, BG=0, cpu_stall=0, dma_done=0, dma_error=0;
  - state=IDLE, grant counter=0, guard counter=0.
  - Reset mid-grant drops BG and cmd at once, with no done pulse.
- States: IDLE, CMD, DRAIN, GRANT, RELEASE.
- IDLE:
  - dma_start=1 at edge k → CMD; cmd=1 and dma_error=0 after edge k.
  - dma_start in any other state is ignored (no queueing).
- CMD:
  - BR=1 and cpu_mem_busy=0 at an edge → GRANT; BG=1 and cpu_stall=1 after that edge.
  - BR=1 and cpu_mem_busy=1 → DRAIN; cpu_stall=1, BG stays 0.
  - BR=0 → stay in CMD; cmd is held.
- DRAIN: first edge with cpu_mem_busy=0 → GRANT; BG=1, cpu_stall stays 1.
- GRANT:
  - BG=1, cmd=1, cpu_stall=1.
  - Grant counter (8-bit) clears on entry and increments each edge in GRANT.
  - BR=0 sampled → RELEASE.
  - Counter reaches GRANT_TIMEOUT-1 with BR still 1 → RELEASE with dma_error=1 (set on the same edge).
  - The BR-drop check takes priority over the timeout check on the same edge: this is a normal completion, not an error.
- RELEASE (exactly one cycle):
  - BG=0, cmd=0, cpu_stall=0, dma_done=1.
  - Next edge → IDLE with dma_done=0.
- Nominal latency:
  - dma_start at edge k with the bus idle → BG high from edge k+2.
  - A DMA that holds BR for 12 granted cycles → dma_done pulses one cycle after BR falls.
- BG and cmd are never high while reset_n=0.
- BG is never high while cpu_mem_busy was sampled high in the same decision cycle.
- cpu_stall covers every cycle in which BG is high.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - After RELEASE, a guard counter loads MIN_CPU_CYCLES.
  - A dma_start accepted during the guard window moves to CMD normally, but CMD will not move to GRANT/DRAIN until the guard counter reaches 0.
  - The counter decrements every cycle outside GRANT.
  - cpu_stall stays 0 during the guard window.
- Undefined: no guard counter is synthesized; CMD may grant on the first eligible edge.

Test Plan:
- Reset then idle 5 cycles → cmd=0, BG=0, cpu_stall=0, dma_done=0, dma_error=0, dma_busy=0.
- dma_start at edge 10, BR follows cmd, cpu_mem_busy=0, DMA holds BR for 12 granted cycles:
  - BG=1 from edge 12;
  - BR falls → one RELEASE cycle with dma_done=1, dma_error=0, dma_busy back to 0.
- dma_start with cpu_mem_busy=1 for 3 cycles after BR rises:
  - cpu_stall=1 during DRAIN, BG=0 for 3 cycles;
  - BG=1 on the first edge after busy clears.
- BR never drops, GRANT_TIMEOUT=32:
  - BG high exactly 32 cycles, then cmd=0, BG=0, dma_done=1, dma_error=1 held;
  - dma_error cleared by the next dma_start.
- reset_n pulled low in the 5th granted cycle → BG=0 and cmd=0 asynchronously, no dma_done; a later dma_start completes normally.
- With ARB_STARVE_GUARD_EN, MIN_CPU_CYCLES=4, dma_start the cycle after dma_done:
  - BG stays low at least 4 cycles after RELEASE;
  - without the macro, BG rises 2 cycles after dma_start.
